apb_req_arbiter: RTL and testbench

- Multi-requester APB master: shares the APB bus between NUM_REQ requesters by round-robin arbitration.
- Sequences each transfer through APB SETUP/ACCESS phases and decodes a one-hot psel to NUM_SLV memory slaves.
- Returns read data and completion to the winning requester.
- Sits between the requester agents and the apb_slave instances; per-slave word address is the low 8 bits.

---
 rtl/apb_req_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin APB master shared by NUM_REQ requesters.
// The winner's payload is latched at grant and sequenced through the APB
// SETUP/ACCESS phases. The slave is chosen by the address bits above [7:0].
// Optional build macro APB_TIMEOUT_EN: when it is defined, ACCESS aborts
// with err=1 after TIMEOUT_CYCLES consecutive wait states.
module apb_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int NUM_SLV        = 4,
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int STR_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*STR_WIDTH-1:0]     req_strb,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               done,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             err,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic                             pwrite,
  output logic                             penable,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [NUM_SLV-1:0]               psel,
  output logic [STR_WIDTH-1:0]             pstrobe,
  input  logic [DATA_WIDTH-1:0]            prdata,
  input  logic                             pready
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SIDX_W = ADDR_WIDTH - 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                 state_reg, state_next;
  logic [PTR_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]       win_reg, win_next;
  logic                   dec_err_reg, dec_err_next;
  logic [NUM_REQ-1:0]     gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]     done_reg, done_next;
  logic [DATA_WIDTH-1:0]  rdata_reg, rdata_next;
  logic                   err_reg, err_next;
  logic [ADDR_WIDTH-1:0]  paddr_reg, paddr_next;
  logic                   pwrite_reg, pwrite_next;
  logic                   penable_reg, penable_next;
  logic [DATA_WIDTH-1:0]  pwdata_reg, pwdata_next;
  logic [NUM_SLV-1:0]     psel_reg, psel_next;
  logic [STR_WIDTH-1:0]   pstrobe_reg, pstrobe_next;

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]        to_cnt_reg, to_cnt_next;
`else
  // ACCESS waits for pready indefinitely; the parameter is kept so both
  // builds share one parameter list.
  localparam int timeout_cycles_unused = TIMEOUT_CYCLES;
`endif

  // Arbitration results and the winner's payload
  logic                   arb_found;
  logic [PTR_W-1:0]       arb_win;
  int                     cand;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [DATA_WIDTH-1:0]  win_wdata;
  logic [STR_WIDTH-1:0]   win_strb;
  logic                   win_write;
  logic [SIDX_W-1:0]      win_sidx;
  logic                   dec_ok;
  logic [NUM_SLV-1:0]     win_psel;
  logic [NUM_REQ-1:0]     win_onehot;
  logic [NUM_REQ-1:0]     cur_onehot;

  // Round-robin search: the first set req at or after the pointer, wrapping around
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_reg) + k) % NUM_REQ;
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_win   = PTR_W'(cand);
      end
    end
  end

  assign win_addr  = req_addr[arb_win*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wdata = req_wdata[arb_win*DATA_WIDTH +: DATA_WIDTH];
  assign win_strb  = req_strb[arb_win*STR_WIDTH +: STR_WIDTH];
  assign win_write = req_write[arb_win];
  assign win_sidx  = win_addr[ADDR_WIDTH-1:8];
  assign dec_ok    = (32'(win_sidx) < NUM_SLV);

  genvar gi;
  // One-hot slave select; stays all-zero when the slave index is out of range
  for (gi = 0; gi < NUM_SLV; gi++) begin : g_psel_dec
    assign win_psel[gi] = dec_ok && (32'(win_sidx) == gi);
  end

  // One-hot views of the new winner (for gnt) and of the latched winner (for done)
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_req_onehot
    assign win_onehot[gi] = (arb_win == PTR_W'(gi));
    assign cur_onehot[gi] = (win_reg == PTR_W'(gi));
  end

  // Next-state and next-output logic; gnt/done/err are pulses and default to 0
  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    win_next     = win_reg;
    dec_err_next = dec_err_reg;
    gnt_next     = '0;
    done_next    = '0;
    err_next     = 1'b0;
    rdata_next   = rdata_reg;
    paddr_next   = paddr_reg;
    pwrite_next  = pwrite_reg;
    penable_next = penable_reg;
    pwdata_next  = pwdata_reg;
    psel_next    = psel_reg;
    pstrobe_next = pstrobe_reg;
`ifdef APB_TIMEOUT_EN
    to_cnt_next  = to_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (arb_found) begin
          win_next     = arb_win;
          rr_ptr_next  = (arb_win == PTR_W'(NUM_REQ - 1)) ? '0 : arb_win + 1'b1;
          gnt_next     = win_onehot;
          paddr_next   = win_addr;
          pwrite_next  = win_write;
          pwdata_next  = win_wdata;
          pstrobe_next = win_write ? win_strb : '0;
          psel_next    = win_psel;
          penable_next = 1'b0;
          dec_err_next = !dec_ok;
          state_next   = SETUP;
        end
      end
      SETUP: begin
        if (dec_err_reg) begin
          // No slave is selected; complete at once with an error
          done_next  = cur_onehot;
          err_next   = 1'b1;
          rdata_next = '0;
          state_next = IDLE;
        end else begin
          penable_next = 1'b1;
          state_next   = ACCESS;
`ifdef APB_TIMEOUT_EN
          to_cnt_next  = '0;
`endif
        end
      end
      ACCESS: begin
        if (pready) begin
          psel_next    = '0;
          penable_next = 1'b0;
          done_next    = cur_onehot;
          rdata_next   = pwrite_reg ? rdata_reg : prdata;
          state_next   = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // The slave never answered: abort, and drop any late pready
          psel_next    = '0;
          penable_next = 1'b0;
          done_next    = cur_onehot;
          err_next     = 1'b1;
          rdata_next   = '0;
          state_next   = IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any transfer in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= '0;
      win_reg     <= '0;
      dec_err_reg <= 1'b0;
      gnt_reg     <= '0;
      done_reg    <= '0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      paddr_reg   <= '0;
      pwrite_reg  <= 1'b0;
      penable_reg <= 1'b0;
      pwdata_reg  <= '0;
      psel_reg    <= '0;
      pstrobe_reg <= '0;
`ifdef APB_TIMEOUT_EN
      to_cnt_reg  <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      win_reg     <= win_next;
      dec_err_reg <= dec_err_next;
      gnt_reg     <= gnt_next;
      done_reg    <= done_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
      paddr_reg   <= paddr_next;
      pwrite_reg  <= pwrite_next;
      penable_reg <= penable_next;
      pwdata_reg  <= pwdata_next;
      psel_reg    <= psel_next;
      pstrobe_reg <= pstrobe_next;
`ifdef APB_TIMEOUT_EN
      to_cnt_reg  <= to_cnt_next;
`endif
    end
  end

  assign gnt     = gnt_reg;
  assign done    = done_reg;
  assign rdata   = rdata_reg;
  assign err     = err_reg;
  assign paddr   = paddr_reg;
  assign pwrite  = pwrite_reg;
  assign penable = penable_reg;
  assign pwdata  = pwdata_reg;
  assign psel    = psel_reg;
  assign pstrobe = pstrobe_reg;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: table-driven transfers against a small APB memory
// slave, plus hand-written contention, reset and timeout sequences.
module tb_apb_req_arbiter;

  localparam int NR = 4;
  localparam int NS = 3;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req, req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*SW-1:0]  req_strb;
  logic [NR-1:0]     gnt, done;
  logic [DW-1:0]     rdata;
  logic              err;
  logic [AW-1:0]     paddr;
  logic              pwrite, penable;
  logic [DW-1:0]     pwdata;
  logic [NS-1:0]     psel;
  logic [SW-1:0]     pstrobe;
  logic [DW-1:0]     prdata;
  logic              pready;

  apb_req_arbiter #(
    .NUM_REQ(NR), .NUM_SLV(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .STR_WIDTH(SW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err), .paddr(paddr),
    .pwrite(pwrite), .penable(penable), .pwdata(pwdata), .psel(psel),
    .pstrobe(pstrobe), .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  // Memory slaves: 256 words each, byte strobes honoured on writes
  logic [DW-1:0] mem [NS*256];
  logic          mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < NS*256; i++) mem[i] <= '0;
      mem_init_done <= 1'b1;
    end else if (penable && pready && pwrite) begin
      for (int s = 0; s < NS; s++)
        if (psel[s])
          for (int b = 0; b < SW; b++)
            if (pstrobe[b]) mem[s*256 + int'(paddr[7:0])][b*8 +: 8] <= pwdata[b*8 +: 8];
    end
  end

  always_comb begin
    prdata = '0;
    for (int s = 0; s < NS; s++)
      if (psel[s]) prdata = mem[s*256 + int'(paddr[7:0])];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  typedef struct {
    int          r;
    logic        wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [NS-1:0] psel;
    logic [DW-1:0] rdata;
    logic        err;
    int          ws;
  } vec_t;

  typedef struct {
    logic [NR-1:0] done_oh;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_rdata"}, 64'(rdata), 0);
    chk({tag, "_err"}, 64'(err), 0);
    chk({tag, "_paddr"}, 64'(paddr), 0);
    chk({tag, "_pctl"}, 64'({pwrite, penable}), 0);
    chk({tag, "_pwdata"}, 64'(pwdata), 0);
    chk({tag, "_psel"}, 64'(psel), 0);
    chk({tag, "_pstrobe"}, 64'(pstrobe), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    pready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete transfer: request, grant, SETUP/ACCESS checks, completion
  task automatic run_xfer(input vec_t v);
    int n;
    exp_t e;
    @(negedge clk);
    req_write[v.r] = v.wr;
    req_addr[v.r*AW +: AW] = v.addr;
    req_wdata[v.r*DW +: DW] = v.wdata;
    req_strb[v.r*SW +: SW] = v.strb;
    req[v.r] = 1'b1;
    pready = (v.ws == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 20);
    chk("gnt", 64'(gnt), 64'(oh(v.r)));
    req[v.r] = 1'b0;
    e.done_oh = oh(v.r);
    e.rdata = v.rdata;
    e.err = v.err;
    e.lat = v.err ? 1 : 2 + v.ws;
    sb.push_back(e);
    chk("setup_psel", 64'(psel), 64'(v.psel));
    chk("setup_penable", 64'(penable), 0);
    chk("paddr", 64'(paddr), 64'(v.addr));
    chk("pwrite", 64'(pwrite), 64'(v.wr));
    chk("pstrobe", 64'(pstrobe), v.wr ? 64'(v.strb) : 64'(0));
    if (v.wr) chk("pwdata", 64'(pwdata), 64'(v.wdata));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("gnt_pulse", 64'(gnt), 0);
      if (done == '0 && n <= 1 + v.ws && !v.err) begin
        chk("access_penable", 64'(penable), 1);
        chk("access_psel", 64'(psel), 64'(v.psel));
        chk("access_paddr", 64'(paddr), 64'(v.addr));
        if (n == 1 + v.ws) pready = 1'b1;
      end
    end while (done == '0 && n < 40);
    e = sb.pop_front();
    chk("done", 64'(done), 64'(e.done_oh));
    chk("latency", 64'(n), 64'(e.lat));
    chk("err", 64'(err), 64'(e.err));
    chk("rdata", 64'(rdata), 64'(e.rdata));
    chk("end_psel", 64'({psel, penable}), 0);
    $display("xfer req%0d %s addr=0x%03h rdata=0x%08h err=%0d latency=%0d",
             v.r, v.wr ? "WR" : "RD", v.addr, rdata, err, n);
    @(negedge clk);
    chk("done_pulse", 64'({done, err}), 0);
  endtask

  initial begin
    int n;
    int order[5];
    exp_t e;
    vec_t v;

    //       r  wr  addr     wdata          strb  psel    rdata          err ws
    vecs[0] = '{0, 1, 10'h005, 32'hDEADBEEF, 4'hF, 3'b001, 32'h00000000, 0, 0};
    vecs[1] = '{0, 0, 10'h005, 32'h0,        4'h0, 3'b001, 32'hDEADBEEF, 0, 0};
    vecs[2] = '{1, 1, 10'h210, 32'h11223344, 4'h5, 3'b100, 32'hDEADBEEF, 0, 0};
    vecs[3] = '{1, 0, 10'h210, 32'h0,        4'h0, 3'b100, 32'h00220044, 0, 0};
    vecs[4] = '{2, 1, 10'h105, 32'hA5A5A5A5, 4'hF, 3'b010, 32'h00220044, 0, 3};
    vecs[5] = '{3, 0, 10'h105, 32'h0,        4'h0, 3'b010, 32'hA5A5A5A5, 0, 3};
    vecs[6] = '{0, 0, 10'h3FF, 32'h0,        4'h0, 3'b000, 32'h00000000, 1, 0};
    vecs[7] = '{1, 0, 10'h005, 32'h0,        4'h0, 3'b001, 32'hDEADBEEF, 0, 0};
    vecs[8] = '{2, 1, 10'h0FF, 32'h12345678, 4'hC, 3'b001, 32'hDEADBEEF, 0, 0};
    vecs[9] = '{2, 0, 10'h0FF, 32'h0,        4'h0, 3'b001, 32'h12340000, 0, 0};

    req = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    pready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_xfer(vecs[i]);

    // Contention: all four requesters hold req; grants rotate from pointer 0
    do_reset();
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NR; i++) begin
      req_write[i] = 1'b0;
      req_addr[i*AW +: AW] = AW'(10'h020 + i);
    end
    @(negedge clk);
    req = '1;
    for (int t = 0; t < 5; t++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (gnt == '0 && n < 20);
      chk("rr_gnt", 64'(gnt), 64'(oh(order[t])));
      e.done_oh = oh(order[t]);
      e.rdata = '0;
      e.err = 1'b0;
      e.lat = 2;
      sb.push_back(e);
      n = 0;
      do begin @(negedge clk); n++; end while (done == '0 && n < 20);
      e = sb.pop_front();
      chk("rr_done", 64'(done), 64'(e.done_oh));
      chk("rr_latency", 64'(n), 64'(e.lat));
      $display("xfer rr turn=%0d gnt=%b done=%b latency=%0d", t, e.done_oh, done, n);
    end
    req = '0;
    @(negedge clk);

    // Reset in the middle of ACCESS: outputs clear at once and no done appears
    do_reset();
    @(negedge clk);
    req_write[0] = 1'b1;
    req_addr[0 +: AW] = 10'h006;
    req_wdata[0 +: DW] = 32'hCAFEF00D;
    req_strb[0 +: SW] = 4'hF;
    pready = 1'b0;
    req[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 20);
    chk("mid_gnt", 64'(gnt), 64'(oh(0)));
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_access", 64'({psel, penable}), 64'({3'b001, 1'b1}));
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    pready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", 64'(done), 0);
    end
    rst_n = 1'b1;
    $display("xfer req0 WR addr=0x006 dropped by reset");
    v = '{2, 1, 10'h011, 32'h0BADCAFE, 4'hF, 3'b001, 32'h00000000, 0, 0};
    run_xfer(v);

`ifdef APB_TIMEOUT_EN
    // Slave stuck with pready low: abort after 16 ACCESS cycles
    @(negedge clk);
    req_write[3] = 1'b0;
    req_addr[3*AW +: AW] = 10'h007;
    pready = 1'b0;
    req[3] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 20);
    chk("to_gnt", 64'(gnt), 64'(oh(3)));
    req[3] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (done == '0 && n < 40);
    chk("to_latency", 64'(n), 17);
    chk("to_done", 64'(done), 64'(oh(3)));
    chk("to_err", 64'(err), 1);
    chk("to_rdata", 64'(rdata), 0);
    chk("to_bus", 64'({psel, penable}), 0);
    $display("xfer req3 RD addr=0x007 timeout err=%0d latency=%0d", err, n);
    pready = 1'b1;
    @(negedge clk);
    chk("to_late_pready", 64'({done, err}), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
